// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants for the SPI master data path.
//                State encodings of the shift-engine FSM, SPI mode constant
//                and the default frame width.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    // Frame width used when the instantiating level does not override it.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // CPOL/CPHA pair. The engine only implements mode 0: sample on the
    // rising edge, change on the falling edge, SCLK idles low.
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    // Shift-engine FSM encodings.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_WAIT_CS = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous input, plus
//                single-cycle rise/fall strobes derived from the synchronised
//                value and its previous sample.
//  Ports       : clk_i   - sampling clock
//                rst_ni  - asynchronous active-low reset (clears all flops)
//                d_i     - asynchronous input
//                q_o     - synchronised level
//                rise_o  - one-cycle pulse on a 0->1 transition of q_o
//                fall_o  - one-cycle pulse on a 1->0 transition of q_o
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o =  q_o & ~prev_q;
    assign fall_o = ~q_o &  prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shift_engine
//  Description : SPI master data path (mode 0). Accepts a TX word on a
//                valid/ready handshake, strobes the external SCLK/nCS
//                generator, follows its sclk/ncs to drive mosi and capture
//                miso, and returns the received word with a one-cycle valid.
//  Ports       : in_clock  - system clock (>= 4x sclk rate)
//                nreset    - asynchronous active-low reset
//                tx_data   - word to send, MSB first
//                tx_valid  - tx_data offered
//                tx_ready  - engine idle, accepts tx_data
//                start     - 2-cycle strobe; falling edge starts a frame
//                spi_sclk  - SCLK from the generator (asynchronous)
//                spi_ncs   - nCS from the generator (asynchronous, active low)
//                spi_miso  - serial data in (asynchronous)
//                spi_mosi  - serial data out
//                rx_data   - received word, held until the next good frame
//                rx_valid  - one-cycle pulse when rx_data updates
//                busy      - FSM is not idle
//                frame_err - one-cycle pulse on an aborted / timed-out frame
//  Revision    : 1.0  initial release
// ============================================================================
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int CS_TIMEOUT  = 255
) (
    input  logic                  in_clock,
    input  logic                  nreset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  start,
    input  logic                  spi_sclk,
    input  logic                  spi_ncs,
    input  logic                  spi_miso,
    output logic                  spi_mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int TO_W  = $clog2(CS_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(DATA_WIDTH);
    // The timeout fires on the cycle the counter would reach CS_TIMEOUT, so
    // frame_err appears exactly CS_TIMEOUT cycles after entering WAIT_CS.
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(CS_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s,  ncs_rise,  ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i  (in_clock),
        .rst_ni (nreset),
        .d_i    (spi_sclk),
        .q_o    (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk_i  (in_clock),
        .rst_ni (nreset),
        .d_i    (spi_ncs),
        .q_o    (ncs_s),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    // miso goes through the same depth as sclk, so the value seen alongside
    // sclk_rise is the line state at the raw rising edge.
    logic [SYNC_STAGES-1:0] miso_sync_q;
    logic                   miso_s;

    always_ff @(posedge in_clock or negedge nreset) begin
        if (!nreset) begin
            miso_sync_q <= '0;
        end else begin
            miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], spi_miso};
        end
    end

    assign miso_s = miso_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [DATA_WIDTH-1:0] rxreg_q,     rxreg_d;
    logic [CNT_W-1:0]      bitcnt_q,    bitcnt_d;
    logic [TO_W-1:0]       to_cnt_q,    to_cnt_d;
    logic                  arm_cnt_q,   arm_cnt_d;
    logic                  mosi_q,      mosi_d;
    logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  start_q,     start_d;
    logic                  tx_ready_q,  tx_ready_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        rxreg_d     = rxreg_q;
        bitcnt_d    = bitcnt_q;
        to_cnt_d    = to_cnt_q;
        arm_cnt_d   = arm_cnt_q;
        mosi_d      = mosi_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shreg_d   = tx_data;
                    bitcnt_d  = '0;
                    arm_cnt_d = 1'b0;
                    state_d   = ST_ARM;
                end
            end

            ST_ARM: begin
                // Two cycles in ARM; start follows the state, so its falling
                // edge coincides with WAIT_CS entry.
                if (arm_cnt_q) begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT_CS;
                end else begin
                    arm_cnt_d = 1'b1;
                end
            end

            ST_WAIT_CS: begin
                if (ncs_fall) begin
                    mosi_d  = shreg_q[DATA_WIDTH-1];
                    state_d = ST_SHIFT;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_SHIFT: begin
                // Edges beyond the frame length are ignored; bitcnt saturates.
                if (sclk_rise && (bitcnt_q != BITS_FULL)) begin
                    rxreg_d  = {rxreg_q[DATA_WIDTH-2:0], miso_s};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                end
                // After the last bit has been sampled mosi is left alone.
                if (sclk_fall && (bitcnt_q != BITS_FULL)) begin
                    shreg_d = shreg_q << 1;
                    mosi_d  = shreg_q[DATA_WIDTH-2];
                end
                // Evaluated on the post-capture count so a final sclk_rise in
                // the same cycle as ncs_rise still completes the frame.
                if (ncs_rise) begin
                    if (bitcnt_d == BITS_FULL) begin
                        rx_data_d  = rxreg_d;
                        rx_valid_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d    = (state_d == ST_ARM);
        tx_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge in_clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            rxreg_q     <= '0;
            bitcnt_q    <= '0;
            to_cnt_q    <= '0;
            arm_cnt_q   <= 1'b0;
            mosi_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            start_q     <= 1'b0;
            tx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rxreg_q     <= rxreg_d;
            bitcnt_q    <= bitcnt_d;
            to_cnt_q    <= to_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            mosi_q      <= mosi_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            start_q     <= start_d;
            tx_ready_q  <= tx_ready_d;
        end
    end

    // sclk/ncs levels are only needed for edge detection.
    logic unused_levels;
    assign unused_levels = sclk_s ^ ncs_s;

    assign tx_ready  = tx_ready_q;
    assign start     = start_q;
    assign spi_mosi  = mosi_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
